lif_step_engine: RTL



---
 rtl/lif_step_engine.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lif_step_engine.sv
// lif_step_engine
//
// Leaky integrate-and-fire membrane update engine. One neuron time step per
// transaction, computed over six datapath states that time-share a single
// sign-magnitude adder and a single sign-magnitude multiplier:
//   DIFF  : d  = v_rest - v
//   DRIVE : g  = gain * i_in
//   SUM   : s  = d + g
//   SCALE : m  = dt_tau * s
//   INTEG : vn = v + m
//   CMP   : threshold / refractory decision, update v
// Values are sign-magnitude: sign in bit N-1, magnitude in N-2:0, Q fraction bits.
//
// Build option: define LIF_SAT_EN to saturate adder carry-out and multiplier
// high-bit overflow to an all-ones magnitude (sign kept). Without it, adder
// magnitudes wrap and multiplier high bits are dropped.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid_i        step request valid
//   in_ready_o        engine idle and out of reset
//   i_in_i            input current
//   v_rest_i, v_reset_i, v_th_i, dt_tau_i, gain_i
//                     neuron constants, sampled with i_in_i on accept
//   refrac_steps_i    refractory length, sampled on accept
//   out_valid_o       result valid (held until out_ready_i)
//   out_ready_i       consumer accepts result
//   v_out_o           updated membrane voltage
//   spike_o           spike fired this step
//   refrac_active_o   refractory counter nonzero
module lif_step_engine #(
    parameter int unsigned N        = 32,
    parameter int unsigned Q        = 16,
    parameter int unsigned REFRAC_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N-1:0]        i_in_i,
    input  logic [N-1:0]        v_rest_i,
    input  logic [N-1:0]        v_reset_i,
    input  logic [N-1:0]        v_th_i,
    input  logic [N-1:0]        dt_tau_i,
    input  logic [N-1:0]        gain_i,
    input  logic [REFRAC_W-1:0] refrac_steps_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N-1:0]        v_out_o,
    output logic                spike_o,
    output logic                refrac_active_o
);

    localparam int unsigned M = N - 1;  // magnitude width

    typedef enum logic [2:0] {
        StIdle, StDiff, StDrive, StSum, StScale, StInteg, StCmp, StOut
    } state_e;

    state_e state_q, state_d;

    // Latched step operands
    logic [N-1:0]        i_in_q, i_in_d;
    logic [N-1:0]        v_rest_q, v_rest_d;
    logic [N-1:0]        v_reset_q, v_reset_d;
    logic [N-1:0]        v_th_q, v_th_d;
    logic [N-1:0]        dt_tau_q, dt_tau_d;
    logic [N-1:0]        gain_q, gain_d;
    logic [REFRAC_W-1:0] refrac_steps_q, refrac_steps_d;

    // Neuron state and intermediates; acc holds d/s/vn, prd holds g/m
    logic [N-1:0]        v_q, v_d;
    logic [REFRAC_W-1:0] refrac_q, refrac_d;
    logic                spike_q, spike_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [N-1:0]        prd_q, prd_d;

    logic accept;

    // Shared adder
    logic [N-1:0] add_a, add_b, add_y;
    logic [M:0]   add_sum;
    logic [M-1:0] add_mag;
    logic         add_sign;
    logic         add_carry;

    // Shared multiplier
    logic [N-1:0]   mul_a, mul_b, mul_y;
    logic [2*M-1:0] mul_prod;
    logic [M-1:0]   mul_mag;
    logic           mul_sign;

    logic vn_ge_th;

    // Sign-magnitude to two's complement; -0 and +0 both map to 0.
    function automatic logic signed [N-1:0] sm_to_tc(input logic [N-1:0] x);
        logic signed [N-1:0] mag;
        mag = signed'({1'b0, x[M-1:0]});
        return x[N-1] ? -mag : mag;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid_i) state_d = StDiff;
            StDiff:  state_d = StDrive;
            StDrive: state_d = StSum;
            StSum:   state_d = StScale;
            StScale: state_d = StInteg;
            StInteg: state_d = StCmp;
            StCmp:   state_d = StOut;
            StOut:   if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o      = (state_q == StIdle) && !reset;
        out_valid_o     = (state_q == StOut);
        v_out_o         = v_q;
        spike_o         = spike_q;
        refrac_active_o = (refrac_q != '0);
    end

    assign accept = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Operand muxing for the shared units
    // ------------------------------------------------------------------
    always_comb begin
        add_a = v_q;
        add_b = prd_q;
        mul_a = dt_tau_q;
        mul_b = acc_q;
        unique case (state_q)
            StDiff: begin
                // Subtraction: flip the subtrahend's sign
                add_a = v_rest_q;
                add_b = {~v_q[N-1], v_q[M-1:0]};
            end
            StSum: begin
                add_a = acc_q;
                add_b = prd_q;
            end
            StDrive: begin
                mul_a = gain_q;
                mul_b = i_in_q;
            end
            default: ;
        endcase
    end

    // Sign-magnitude adder
    always_comb begin
        add_sum   = {1'b0, add_a[M-1:0]} + {1'b0, add_b[M-1:0]};
        add_carry = 1'b0;
        if (add_a[N-1] == add_b[N-1]) begin
            add_mag   = add_sum[M-1:0];
            add_sign  = add_a[N-1];
            add_carry = add_sum[M];
        end else if (add_a[M-1:0] >= add_b[M-1:0]) begin
            add_mag  = add_a[M-1:0] - add_b[M-1:0];
            add_sign = add_a[N-1];
        end else begin
            add_mag  = add_b[M-1:0] - add_a[M-1:0];
            add_sign = add_b[N-1];
        end
`ifdef LIF_SAT_EN
        if (add_carry) add_mag = '1;
`endif
        if (add_mag == '0) add_sign = 1'b0;
        add_y = {add_sign, add_mag};
    end

    // Sign-magnitude multiplier; keeps product bits [M-1+Q:Q]
    assign mul_prod = {{M{1'b0}}, mul_a[M-1:0]} * {{M{1'b0}}, mul_b[M-1:0]};

    always_comb begin
        mul_mag  = mul_prod[M-1+Q:Q];
        mul_sign = mul_a[N-1] ^ mul_b[N-1];
`ifdef LIF_SAT_EN
        if (mul_prod[2*M-1:M+Q] != '0) mul_mag = '1;
`endif
        if (mul_mag == '0) mul_sign = 1'b0;
        mul_y = {mul_sign, mul_mag};
    end

    // Truncated product bits and (unsaturated) carry are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{mul_prod, add_carry};

    assign vn_ge_th = (sm_to_tc(acc_q) >= sm_to_tc(v_th_q));

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        i_in_d         = i_in_q;
        v_rest_d       = v_rest_q;
        v_reset_d      = v_reset_q;
        v_th_d         = v_th_q;
        dt_tau_d       = dt_tau_q;
        gain_d         = gain_q;
        refrac_steps_d = refrac_steps_q;
        v_d            = v_q;
        refrac_d       = refrac_q;
        spike_d        = spike_q;
        acc_d          = acc_q;
        prd_d          = prd_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    i_in_d         = i_in_i;
                    v_rest_d       = v_rest_i;
                    v_reset_d      = v_reset_i;
                    v_th_d         = v_th_i;
                    dt_tau_d       = dt_tau_i;
                    gain_d         = gain_i;
                    refrac_steps_d = refrac_steps_i;
                end
            end
            StDiff:  acc_d = add_y;
            StDrive: prd_d = mul_y;
            StSum:   acc_d = add_y;
            StScale: prd_d = mul_y;
            StInteg: acc_d = add_y;
            StCmp: begin
                if (refrac_q != '0) begin
                    // Refractory: arithmetic result is discarded
                    v_d      = v_reset_q;
                    spike_d  = 1'b0;
                    refrac_d = refrac_q - REFRAC_W'(1);
                end else if (vn_ge_th) begin
                    v_d      = v_reset_q;
                    spike_d  = 1'b1;
                    refrac_d = refrac_steps_q;
                end else begin
                    v_d     = acc_q;
                    spike_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_in_q         <= '0;
            v_rest_q       <= '0;
            v_reset_q      <= '0;
            v_th_q         <= '0;
            dt_tau_q       <= '0;
            gain_q         <= '0;
            refrac_steps_q <= '0;
            v_q            <= '0;
            refrac_q       <= '0;
            spike_q        <= 1'b0;
            acc_q          <= '0;
            prd_q          <= '0;
        end else begin
            i_in_q         <= i_in_d;
            v_rest_q       <= v_rest_d;
            v_reset_q      <= v_reset_d;
            v_th_q         <= v_th_d;
            dt_tau_q       <= dt_tau_d;
            gain_q         <= gain_d;
            refrac_steps_q <= refrac_steps_d;
            v_q            <= v_d;
            refrac_q       <= refrac_d;
            spike_q        <= spike_d;
            acc_q          <= acc_d;
            prd_q          <= prd_d;
        end
    end

endmodule
